// File: rtl/toccata_input_gain.sv
`default_nettype none
// ============================================================================
// Module      : toccata_input_gain
// Description : Record-path input gain for captured stereo ADC samples.
//               Applies 0..+22.5 dB in 1.5 dB steps from a constant Q4.12
//               factor table. The gain index slews one step per sample toward
//               its target so there is no zipper noise. Results are saturated
//               to 16 bit. Sticky clip flags and peak meters are kept per
//               channel. Two-stage pipeline with a throughput of one sample
//               per clock.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               in_valid_i          - strobe, audio_in_*_i holds a new sample
//               audio_in_left/right_i  - signed 16-bit captured samples
//               gain_left/right_i   - target gain index (0 = 0 dB)
//               mute_i              - zero both outputs, pipeline keeps going
//               clip_clear_i        - strobe, clear clip flags and peaks
//               out_valid_o         - strobe, audio_out_*_o updated
//               audio_out_left/right_o - signed gained, saturated samples
//               clip_left/right_o   - sticky saturation flags
//               peak_left/right_o   - max |output| since the last clear
// Revision    : 1.0 - initial release
// ============================================================================
module toccata_input_gain #(
  parameter int GAIN_STEPS = 16,
  parameter int FRAC_BITS  = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  input  logic [15:0] audio_in_left_i,
  input  logic [15:0] audio_in_right_i,
  input  logic [3:0]  gain_left_i,
  input  logic [3:0]  gain_right_i,
  input  logic        mute_i,
  input  logic        clip_clear_i,
  output logic        out_valid_o,
  output logic [15:0] audio_out_left_o,
  output logic [15:0] audio_out_right_o,
  output logic        clip_left_o,
  output logic        clip_right_o,
  output logic [14:0] peak_left_o,
  output logic [14:0] peak_right_o
);

  localparam int c_idx_w = $clog2(GAIN_STEPS);
  localparam int c_sw    = 33 - FRAC_BITS;   // width of the shifted product
  localparam logic signed [c_sw-1:0] c_pos_lim = c_sw'(32767);
  localparam logic signed [c_sw-1:0] c_neg_lim = c_sw'(-32768);

  // round(4096 * 10^(1.5*i/20)); entry 15 is pinned to 54620.
  function automatic logic [15:0] f_gain_factor(input logic [c_idx_w-1:0] idx);
    logic [15:0] f;
    case (idx)
      4'd0:    f = 16'd4096;
      4'd1:    f = 16'd4868;
      4'd2:    f = 16'd5786;
      4'd3:    f = 16'd6876;
      4'd4:    f = 16'd8173;
      4'd5:    f = 16'd9713;
      4'd6:    f = 16'd11544;
      4'd7:    f = 16'd13720;
      4'd8:    f = 16'd16306;
      4'd9:    f = 16'd19380;
      4'd10:   f = 16'd23034;
      4'd11:   f = 16'd27375;
      4'd12:   f = 16'd32536;
      4'd13:   f = 16'd38669;
      4'd14:   f = 16'd45958;
      4'd15:   f = 16'd54620;
      default: f = 16'd4096;
    endcase
    return f;
  endfunction

  // Channel 0 = left, channel 1 = right.
  logic [15:0]        w_in   [2];
  logic [c_idx_w-1:0] w_tgt  [2];
  logic [15:0]        w_out  [2];
  logic               w_clip [2];
  logic [14:0]        w_peak [2];

  assign w_in[0]  = audio_in_left_i;
  assign w_in[1]  = audio_in_right_i;
  assign w_tgt[0] = gain_left_i;
  assign w_tgt[1] = gain_right_i;

  // Pipeline valids are shared by both channels.
  logic v1_q;
  logic out_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      v1_q        <= in_valid_i;
      out_valid_q <= v1_q;
    end
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic [c_idx_w-1:0]     cur_q, cur_d;
    logic signed [32:0]     prod_q, prod_d;
    logic [15:0]            out_q, out_d;
    logic                   clip_q, clip_d;
    logic [14:0]            peak_q, peak_d;
    logic signed [c_sw-1:0] w_shift;
    logic [15:0]            w_sat;
    logic                   w_sat_hit;
    logic [15:0]            w_neg;
    logic [14:0]            w_abs;

    // Slew one index step per accepted sample; this sample still uses the
    // pre-step index (cur_q).
    always_comb begin
      cur_d = cur_q;
      if (in_valid_i) begin
        if (w_tgt[ch] > cur_q) begin
          cur_d = cur_q + 1'b1;
        end else if (w_tgt[ch] < cur_q) begin
          cur_d = cur_q - 1'b1;
        end
      end
    end

    assign prod_d = 33'($signed(w_in[ch])) * 33'($signed({1'b0, f_gain_factor(cur_q)}));

    // Dropping the low FRAC_BITS of a two's-complement value is a floor shift.
    assign w_shift = prod_q[32:FRAC_BITS];

    always_comb begin
      w_sat     = w_shift[15:0];
      w_sat_hit = 1'b0;
      if (w_shift > c_pos_lim) begin
        w_sat     = 16'h7FFF;
        w_sat_hit = 1'b1;
      end else if (w_shift < c_neg_lim) begin
        w_sat     = 16'h8000;
        w_sat_hit = 1'b1;
      end
    end

    assign out_d = v1_q ? (mute_i ? 16'h0000 : w_sat) : out_q;

    // |out| of the value being loaded, with -32768 folded onto 32767.
    assign w_neg = (~out_d) + 16'd1;
    always_comb begin
      w_abs = out_d[14:0];
      if (out_d == 16'h8000) begin
        w_abs = 15'h7FFF;
      end else if (out_d[15]) begin
        w_abs = w_neg[14:0];
      end
    end

    // A saturation event in the same cycle beats a clear.
    always_comb begin
      clip_d = clip_q;
      if (v1_q && w_sat_hit && !mute_i) begin
        clip_d = 1'b1;
      end else if (clip_clear_i) begin
        clip_d = 1'b0;
      end
    end

    // A clear coinciding with a new sample restarts the meter from that sample.
    always_comb begin
      peak_d = peak_q;
      if (v1_q) begin
        if (clip_clear_i) begin
          peak_d = w_abs;
        end else if (w_abs > peak_q) begin
          peak_d = w_abs;
        end
      end else if (clip_clear_i) begin
        peak_d = 15'd0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cur_q  <= '0;
        prod_q <= '0;
        out_q  <= '0;
        clip_q <= 1'b0;
        peak_q <= '0;
      end else begin
        cur_q  <= cur_d;
        if (in_valid_i) begin
          prod_q <= prod_d;
        end
        out_q  <= out_d;
        clip_q <= clip_d;
        peak_q <= peak_d;
      end
    end

    assign w_out[ch]  = out_q;
    assign w_clip[ch] = clip_q;
    assign w_peak[ch] = peak_q;
  end

  assign out_valid_o       = out_valid_q;
  assign audio_out_left_o  = w_out[0];
  assign audio_out_right_o = w_out[1];
  assign clip_left_o       = w_clip[0];
  assign clip_right_o      = w_clip[1];
  assign peak_left_o       = w_peak[0];
  assign peak_right_o      = w_peak[1];

endmodule
`default_nettype wire

// File: tb/tb_toccata_input_gain.sv
`default_nettype none
// ============================================================================
// Module      : tb_toccata_input_gain
// Description : Directed self-checking bench for toccata_input_gain.
//               Expected values are hand-computed from the gain table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_toccata_input_gain;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_l = '0;
  logic [15:0] in_r = '0;
  logic [3:0]  gain_l = '0;
  logic [3:0]  gain_r = '0;
  logic        mute = 1'b0;
  logic        clip_clear = 1'b0;
  logic        out_valid;
  logic [15:0] out_l, out_r;
  logic        clip_l, clip_r;
  logic [14:0] peak_l, peak_r;

  int n_cmp  = 0;
  int n_fail = 0;

  int ramp_exp [10] = '{256, 304, 361, 429, 510, 607, 721, 857, 1019, 1019};

  toccata_input_gain dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid_i        (in_valid),
    .audio_in_left_i   (in_l),
    .audio_in_right_i  (in_r),
    .gain_left_i       (gain_l),
    .gain_right_i      (gain_r),
    .mute_i            (mute),
    .clip_clear_i      (clip_clear),
    .out_valid_o       (out_valid),
    .audio_out_left_o  (out_l),
    .audio_out_right_o (out_r),
    .clip_left_o       (clip_l),
    .clip_right_o      (clip_r),
    .peak_left_o       (peak_l),
    .peak_right_o      (peak_r)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_ov",     32'(out_valid), 32'd0);
    chk("rst_out_l",  32'(out_l),     32'd0);
    chk("rst_out_r",  32'(out_r),     32'd0);
    chk("rst_clip_l", 32'(clip_l),    32'd0);
    chk("rst_clip_r", 32'(clip_r),    32'd0);
    chk("rst_peak_l", 32'(peak_l),    32'd0);
    chk("rst_peak_r", 32'(peak_r),    32'd0);
    rst = 1'b0;
    tick();

    // Unity gain, latency of exactly two clocks, hold between strobes
    in_valid = 1'b1; in_l = 16'h1234; in_r = 16'hEDCC;
    tick();
    in_valid = 1'b0;
    chk("lat_ov_c1", 32'(out_valid), 32'd0);
    tick();
    chk("lat_ov_c2",   32'(out_valid), 32'd1);
    chk("unity_l",     32'(out_l),     32'h1234);
    chk("unity_r",     32'(out_r),     32'hEDCC);
    chk("unity_clipl", 32'(clip_l),    32'd0);
    chk("unity_clipr", 32'(clip_r),    32'd0);
    chk("unity_peakl", 32'(peak_l),    32'h1234);
    chk("unity_peakr", 32'(peak_r),    32'h1234);
    tick();
    chk("lat_ov_c3", 32'(out_valid), 32'd0);
    chk("hold_l",    32'(out_l),     32'h1234);

    // Ramp 0 -> 8 on left with back-to-back samples
    rst = 1'b1;
    tick();
    rst = 1'b0;
    gain_l = 4'd8; gain_r = 4'd0;
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) begin
        in_valid = 1'b1; in_l = 16'h0100; in_r = 16'h0100;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i == 0) begin
        chk("ramp_ov0", 32'(out_valid), 32'd0);
      end else begin
        chk($sformatf("ramp_ov%0d", i), 32'(out_valid), 32'd1);
        chk($sformatf("ramp_l%0d", i),  32'(out_l),     32'(ramp_exp[i-1]));
        chk($sformatf("ramp_r%0d", i),  32'(out_r),     32'h0100);
      end
    end
    tick();
    chk("ramp_ov_end", 32'(out_valid), 32'd0);

    // Clear alone zeroes the meters
    clip_clear = 1'b1;
    tick();
    clip_clear = 1'b0;
    chk("clr_peak_l", 32'(peak_l), 32'd0);
    chk("clr_peak_r", 32'(peak_r), 32'd0);

    // Slew both channels to 15 with silent samples
    gain_l = 4'd15; gain_r = 4'd15;
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'b1; in_l = 16'h0000; in_r = 16'h0000;
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();

    // Saturation at +22.5 dB, including |-32768| -> 32767
    in_valid = 1'b1; in_l = 16'h4000; in_r = 16'h8000;
    tick();
    in_valid = 1'b0;
    tick();
    chk("sat_ov",     32'(out_valid), 32'd1);
    chk("sat_l",      32'(out_l),     32'h7FFF);
    chk("sat_r",      32'(out_r),     32'h8000);
    chk("sat_clip_l", 32'(clip_l),    32'd1);
    chk("sat_clip_r", 32'(clip_r),    32'd1);
    chk("sat_peak_l", 32'(peak_l),    32'h7FFF);
    chk("sat_peak_r", 32'(peak_r),    32'h7FFF);

    // Clear coincident with a non-saturating sample: meters restart from it
    in_valid = 1'b1; in_l = 16'h0100; in_r = 16'hFF00;
    tick();
    in_valid = 1'b0; clip_clear = 1'b1;
    tick();
    clip_clear = 1'b0;
    chk("cc_l",      32'(out_l),  32'h0D55);
    chk("cc_r",      32'(out_r),  32'hF2AA);
    chk("cc_peak_l", 32'(peak_l), 32'h0D55);
    chk("cc_peak_r", 32'(peak_r), 32'h0D56);
    chk("cc_clip_l", 32'(clip_l), 32'd0);
    chk("cc_clip_r", 32'(clip_r), 32'd0);

    // Smaller sample leaves the peak alone
    in_valid = 1'b1; in_l = 16'h0010; in_r = 16'hFFF0;
    tick();
    in_valid = 1'b0;
    tick();
    chk("small_l",      32'(out_l),  32'h00D5);
    chk("small_r",      32'(out_r),  32'hFF2A);
    chk("small_peak_l", 32'(peak_l), 32'h0D55);
    chk("small_peak_r", 32'(peak_r), 32'h0D56);

    // Clear coincident with a saturating sample: set wins
    in_valid = 1'b1; in_l = 16'h4000; in_r = 16'h8000;
    tick();
    in_valid = 1'b0; clip_clear = 1'b1;
    tick();
    clip_clear = 1'b0;
    chk("ccs_clip_l", 32'(clip_l), 32'd1);
    chk("ccs_clip_r", 32'(clip_r), 32'd1);
    chk("ccs_peak_l", 32'(peak_l), 32'h7FFF);

    // Later clear
    tick();
    clip_clear = 1'b1;
    tick();
    clip_clear = 1'b0;
    chk("lc_clip_l", 32'(clip_l), 32'd0);
    chk("lc_clip_r", 32'(clip_r), 32'd0);
    chk("lc_peak_l", 32'(peak_l), 32'd0);
    chk("lc_peak_r", 32'(peak_r), 32'd0);

    // Mute at full gain with a saturating input
    mute = 1'b1;
    in_valid = 1'b1; in_l = 16'h4000; in_r = 16'h8000;
    tick();
    in_valid = 1'b0;
    tick();
    chk("mute_ov",     32'(out_valid), 32'd1);
    chk("mute_l",      32'(out_l),     32'd0);
    chk("mute_r",      32'(out_r),     32'd0);
    chk("mute_clip_l", 32'(clip_l),    32'd0);
    chk("mute_peak_l", 32'(peak_l),    32'd0);
    mute = 1'b0;
    tick();

    // Reset mid-ramp and mid-pipeline
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_l = 16'h0100; in_r = 16'h0100;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("mrst_ov_a", 32'(out_valid), 32'd0);
    rst = 1'b0;
    tick();
    chk("mrst_ov_b", 32'(out_valid), 32'd0);
    tick();
    chk("mrst_ov_c", 32'(out_valid), 32'd0);
    in_valid = 1'b1; in_l = 16'h0100; in_r = 16'h0100;
    tick();
    in_valid = 1'b0;
    tick();
    chk("mrst_ov_d", 32'(out_valid), 32'd1);
    chk("mrst_l",    32'(out_l),     32'h0100);
    chk("mrst_r",    32'(out_r),     32'h0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
